// File: rtl/bcd_seq_converter_if.sv
// Handshake and result bundle between a requester and bcd_seq_converter.
// The requester drives start/num and observes busy/done plus the held result.
interface bcd_seq_converter_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) ();
    logic                  start;
    logic [WIDTH-1:0]      num;
    logic                  busy;
    logic                  done;
    logic                  sign;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, output num, input busy, input done, input sign, input bcd);
    modport slave  (input start, input num, output busy, output done, output sign, output bcd);
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble: signed WIDTH-bit value in, sign flag plus packed
// BCD magnitude out, one shift-add-3 iteration per clock with a done pulse.
module bcd_seq_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst,
    bcd_seq_converter_if.slave bus
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [SW-1:0]    scratch, scratch_n, adj;
    logic [WIDTH-1:0] mag, mag_n;
    logic             sign_r, sign_r_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             sign_q, sign_n;
    logic [SW-1:0]    bcd_q, bcd_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            scratch <= '0;
            mag     <= '0;
            sign_r  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            scratch <= scratch_n;
            mag     <= mag_n;
            sign_r  <= sign_r_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            sign_q  <= sign_n;
            bcd_q   <= bcd_n;
        end
    end

    // Add-3 correction on every digit that would overflow past 9 after doubling.
    always_comb begin
        adj = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        scratch_n = scratch;
        mag_n     = mag;
        sign_r_n  = sign_r;
        busy_n    = busy_q;
        done_n    = 1'b0;
        sign_n    = sign_q;
        bcd_n     = bcd_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    sign_r_n  = bus.num[WIDTH-1];
                    mag_n     = bus.num[WIDTH-1] ? (~bus.num + WIDTH'(1)) : bus.num;
                    scratch_n = '0;
                    cnt_n     = '0;
                    busy_n    = 1'b1;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_n = {adj[SW-2:0], mag[WIDTH-1]};
                mag_n     = {mag[WIDTH-2:0], 1'b0};
                cnt_n     = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1))
                    state_n = FINISH;
            end
            FINISH: begin
                bcd_n   = scratch;
                sign_n  = sign_r;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sign = sign_q;
    assign bus.bcd  = bcd_q;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: stimulus pushes expected {sign,bcd},
// a negedge monitor pops on each done pulse and watches output stability.
module tb_bcd_seq_converter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_seq_converter_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [12:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [12:0] ref_conv(input logic [7:0] v);
        int m;
        m = v[7] ? (256 - int'(v)) : int'(v);
        return {v[7], 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Monitor: result checks on done, spacing between dones, output stability.
    initial begin
        logic [12:0] prev;
        logic [12:0] e;
        int cyc  = 0;
        int last = -100;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.bcd), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("done_result", 32'({bus.sign, bus.bcd}), 32'(e));
                end
                check("done_spacing_ok", 32'(cyc - last >= 10), 32'd1);
                last = cyc;
            end else if (!rst && ({bus.sign, bus.bcd} !== prev)) begin
                check("output_stable", 32'({bus.sign, bus.bcd}), 32'(prev));
            end
            prev = {bus.sign, bus.bcd};
        end
    end

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic convert(input logic [7:0] v, input logic [12:0] e);
        wait_idle();
        bus.start = 1'b1;
        bus.num   = v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.num   = 8'($urandom);
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        int k;
        logic [7:0] v;
        bus.start = 1'b0;
        bus.num   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sign", 32'(bus.sign), 32'd0);
        check("reset_bcd",  32'(bus.bcd),  32'd0);
        rst = 1'b0;

        // Zero conversion with latency and busy-length checks
        @(negedge clk);
        bus.start = 1'b1;
        bus.num   = 8'd0;
        exp_q.push_back({1'b0, 12'h000});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1 && done_at == 0) done_at = i;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd9);
        check("done_latency", 32'(done_at), 32'd10);

        convert(8'd127, {1'b0, 12'h127});
        convert(8'd100, {1'b0, 12'h100});
        convert(8'h80,  {1'b1, 12'h128});
        convert(8'hFF,  {1'b1, 12'h001});

        // 45 then start held with 99 through busy and the done cycle
        wait_idle();
        bus.start = 1'b1;
        bus.num   = 8'd45;
        exp_q.push_back({1'b0, 12'h045});
        @(posedge clk);
        #1;
        bus.num = 8'd99;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.done !== 1'b1 && k < 30);
        check("held_first_done_seen", 32'(k < 30), 32'd1);
        exp_q.push_back({1'b0, 12'h099});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.done !== 1'b1 && k < 30);
        check("back_to_back_gap", 32'(k), 32'd10);

        // Abort 88 with reset in its 4th busy cycle
        wait_idle();
        bus.start = 1'b1;
        bus.num   = 8'd88;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sign", 32'(bus.sign), 32'd0);
        check("abort_bcd",  32'(bus.bcd),  32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        convert(8'hF6, {1'b1, 12'h010});

        for (int i = 0; i < 500; i++) begin
            v = 8'($urandom_range(0, 255));
            convert(v, ref_conv(v));
        end

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
